// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: funct3 codes, FSM states and byte-mask constants shared by the LSU.
package mem_lsu_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [3:0] MASK_WORD = 4'hF;

    typedef enum logic [1:0] {IDLE, ISSUE, ISSUE_HI, RESP} lsu_state_t;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return we ? (f3 > F3_W) : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction
endpackage

// File: rtl/mem_lsu_load_ext.sv
// mem_lsu_load_ext: selects the addressed byte/half of a memory word and sign/zero extends it.
module mem_lsu_load_ext
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = 8'(word_i >> {off_i, 3'b000});
        h = off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
                 funct3_i == F3_BU ? {24'b0, b} :
                 funct3_i == F3_H  ? {{16{h[15]}}, h} :
                 funct3_i == F3_HU ? {16'b0, h} : word_i;
    end
endmodule

// File: rtl/mem_lsu_ctrl.sv
// mem_lsu_ctrl: RV32I load/store sequencer to a registered-read, byte-lane-write word memory.
// MEM_LSU_MISALIGN_EXC_EN: misaligned half/word accesses error out instead of being aligned down.
module mem_lsu_ctrl
    import mem_lsu_pkg::*;
#(
    parameter int ADDW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err,
    output logic [ADDW-1:0] mem_address,
    output logic            mem_ld,
    output logic            mem_str,
    output logic [3:0]      mem_byte_masking,
    output logic [31:0]     mem_data_in,
    input  logic [31:0]     mem_data_out
);
    lsu_state_t      state_q, state_d;
    logic            we_q, we_d, err_q, err_d;
    logic [2:0]      f3_q, f3_d;
    logic [ADDW+1:0] addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            accept, misalign, issue;
    logic [1:0]      lane;
    logic [7:0]      st_byte;
    logic [31:0]     ld_data;
    logic            unused_addr_hi;

    // Address bits above the memory size wrap away.
    assign unused_addr_hi = ^req_addr[31:ADDW+2];

    always_comb begin
        accept = req_valid && state_q == IDLE;
`ifdef MEM_LSU_MISALIGN_EXC_EN
        misalign = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        we_d    = accept ? req_we : we_q;
        f3_d    = accept ? req_funct3 : f3_q;
        wdata_d = accept ? req_wdata : wdata_q;
        err_d   = accept ? (f3_illegal(req_we, req_funct3) || misalign) : err_q;
        // Halves drop addr[0], words drop addr[1:0]; illegal codes never reach memory.
        addr_d  = accept ? {req_addr[ADDW+1:2],
                            req_funct3[1] ? 2'b00 : req_funct3[0] ? {req_addr[1], 1'b0} : req_addr[1:0]}
                         : addr_q;
        state_d = state_q;
        unique case (state_q)
            IDLE:     state_d = accept ? (err_d ? RESP : ISSUE) : IDLE;
            ISSUE:    state_d = (we_q && f3_q == F3_H) ? ISSUE_HI : RESP;
            ISSUE_HI: state_d = RESP;
            RESP:     state_d = IDLE;
        endcase
    end

    always_comb begin
        issue            = state_q == ISSUE || state_q == ISSUE_HI;
        lane             = state_q == ISSUE_HI ? addr_q[1:0] + 2'd1 : addr_q[1:0];
        st_byte          = state_q == ISSUE_HI ? wdata_q[15:8] : wdata_q[7:0];
        mem_address      = issue ? addr_q[ADDW+1:2] : '0;
        mem_ld           = state_q == ISSUE && !we_q;
        mem_str          = issue && we_q;
        mem_byte_masking = !issue ? 4'h0 : (!we_q || f3_q == F3_W) ? MASK_WORD : {2'b00, lane};
        mem_data_in      = !mem_str ? '0 : f3_q == F3_W ? wdata_q : 32'(st_byte) << {lane, 3'b000};
        req_ready        = state_q == IDLE;
        rsp_valid        = state_q == RESP;
        rsp_err          = rsp_valid && err_q;
        rsp_rdata        = (rsp_valid && !we_q && !err_q) ? ld_data : '0;
    end

    mem_lsu_load_ext u_load_ext (
        .funct3_i (f3_q),
        .off_i    (addr_q[1:0]),
        .word_i   (mem_data_out),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// tb_mem_lsu_ctrl: directed and random load/store traffic checked cycle by cycle against a byte-array model.
module tb_mem_lsu_ctrl;
    localparam int ADDW = 12;
    localparam int NB   = 4 << ADDW;

    typedef struct {
        logic            ready;
        logic            rv;
        logic            err;
        logic            ld;
        logic            str;
        logic [31:0]     rdata;
        logic [3:0]      mask;
        logic [ADDW-1:0] addr;
        logic [31:0]     din;
        logic [31:0]     dmask;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid, req_ready, req_we;
    logic [2:0]      req_funct3;
    logic [31:0]     req_addr, req_wdata;
    logic            rsp_valid, rsp_err;
    logic [31:0]     rsp_rdata;
    logic [ADDW-1:0] mem_address;
    logic            mem_ld, mem_str;
    logic [3:0]      mem_byte_masking;
    logic [31:0]     mem_data_in;
    logic [31:0]     mem_data_out = '0;

    logic [31:0] mem [0:(1<<ADDW)-1];
    logic [7:0]  ref_b [0:NB-1];
    exp_t        exp_q[$];
    int          vectors = 0;
    int          errs = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always #5 clk = ~clk;

    mem_lsu_ctrl #(.ADDW(ADDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_ld(mem_ld), .mem_str(mem_str),
        .mem_byte_masking(mem_byte_masking), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Environment memory: registered read, single-lane or full-word write.
    always @(posedge clk) begin
        if (mem_ld) mem_data_out <= mem[mem_address];
        if (mem_str) begin
            if (mem_byte_masking == 4'hF) mem[mem_address] <= mem_data_in;
            else mem[mem_address][8*mem_byte_masking[1:0] +: 8] <= mem_data_in[8*mem_byte_masking[1:0] +: 8];
        end
    end

    function automatic void chk(string n, logic [31:0] got, logic [31:0] want);
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
        end
    endfunction

    task automatic lit(string n, logic [31:0] got, logic [31:0] want);
        vectors++;
        chk(n, got, want);
    endtask

    function automatic exp_t idle_e();
        exp_t e = '{default: '0};
        e.ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t resp_e(logic err, logic [31:0] rd);
        exp_t e = '{default: '0};
        e.rv = 1'b1;
        e.err = err;
        e.rdata = rd;
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("req_ready", 32'(req_ready), 32'(e.ready));
                chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("mem_ld", 32'(mem_ld), 32'(e.ld));
                chk("mem_str", 32'(mem_str), 32'(e.str));
                if (e.ld || e.str) begin
                    chk("mem_byte_masking", 32'(mem_byte_masking), 32'(e.mask));
                    chk("mem_address", 32'(mem_address), 32'(e.addr));
                end
                if (e.str) chk("mem_data_in", mem_data_in & e.dmask, e.din & e.dmask);
                if (rsp_valid) begin
                    last_rdata = rsp_rdata;
                    last_err = rsp_err;
                end
            end
        end
    end

    task automatic junk();
        req_valid  = 1'($urandom);
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            junk();
            req_valid = 1'b0;
            exp_q.push_back(idle_e());
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit abort_hi);
        int size, ba, wb, lane;
        bit legal, err;
        exp_t e;
        logic [31:0] w, rd;
        logic [7:0] bb;
        logic [15:0] hh;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MEM_LSU_MISALIGN_EXC_EN
        err = !legal || (a % size != 0);
`else
        err = !legal;
`endif
        ba = int'(a & ~32'(size - 1) & 32'(NB - 1));
        wb = ba & ~3;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        exp_q.push_back(idle_e());
        if (err) begin
            @(negedge clk); junk();
            exp_q.push_back(resp_e(1'b1, '0));
        end else if (!we) begin
            @(negedge clk); junk();
            e = '{default: '0};
            e.ld = 1'b1; e.mask = 4'hF; e.addr = ADDW'(ba >> 2);
            exp_q.push_back(e);
            w  = {ref_b[wb+3], ref_b[wb+2], ref_b[wb+1], ref_b[wb]};
            bb = 8'(w >> (8 * (ba % 4)));
            hh = 16'(w >> (8 * (ba % 4)));
            rd = f3 == 3'd0 ? {{24{bb[7]}}, bb} : f3 == 3'd4 ? {24'b0, bb} :
                 f3 == 3'd1 ? {{16{hh[15]}}, hh} : f3 == 3'd5 ? {16'b0, hh} : w;
            @(negedge clk); junk();
            exp_q.push_back(resp_e(1'b0, rd));
        end else begin
            if (size == 4) begin
                @(negedge clk); junk();
                e = '{default: '0};
                e.str = 1'b1; e.mask = 4'hF; e.addr = ADDW'(ba >> 2); e.din = wd; e.dmask = '1;
                exp_q.push_back(e);
                for (int k = 0; k < 4; k++) ref_b[ba+k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < size; k++) begin
                    @(negedge clk); junk();
                    lane = (ba + k) % 4;
                    e = '{default: '0};
                    e.str = 1'b1; e.mask = 4'(lane); e.addr = ADDW'((ba + k) >> 2);
                    e.din = {24'b0, wd[8*k +: 8]} << (8 * lane);
                    e.dmask = 32'hFF << (8 * lane);
                    exp_q.push_back(e);
                    if (abort_hi && k == 1) begin
                        #3 rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0; req_valid = 1'b0;
                        exp_q.push_back(idle_e());
                        #3;
                        return;
                    end
                    ref_b[ba+k] = wd[8*k +: 8];
                end
            end
            @(negedge clk); junk();
            exp_q.push_back(resp_e(1'b0, '0));
        end
        #3;
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < (1 << ADDW); i++) begin
            a = $urandom;
            mem[i] = a;
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = a[8*k +: 8];
        end
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        #1 rst = 1'b1;
        @(negedge clk); exp_q.push_back(idle_e());
        @(negedge clk); rst = 1'b0; exp_q.push_back(idle_e());

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
        lit("lw_0x10", last_rdata, 32'hDEADBEEF);

        do_req(1'b1, 3'd2, 32'h20, 32'h80FF7F01, 0);
        do_req(1'b0, 3'd0, 32'h23, 32'h0, 0);
        lit("lb_0x23", last_rdata, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h23, 32'h0, 0);
        lit("lbu_0x23", last_rdata, 32'h00000080);
        do_req(1'b0, 3'd1, 32'h22, 32'h0, 0);
        lit("lh_0x22", last_rdata, 32'hFFFF80FF);
        do_req(1'b0, 3'd5, 32'h20, 32'h0, 0);
        lit("lhu_0x20", last_rdata, 32'h00007F01);

        do_req(1'b1, 3'd2, 32'h30, 32'h11223344, 0);
        do_req(1'b1, 3'd1, 32'h32, 32'h0000A55A, 0);
        do_req(1'b0, 3'd2, 32'h30, 32'h0, 0);
        lit("sh_then_lw_0x30", last_rdata, 32'hA55A3344);

        do_req(1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 0);
        do_req(1'b0, 3'd2, 32'h41, 32'h0, 0);
`ifdef MEM_LSU_MISALIGN_EXC_EN
        lit("lw_0x41_rdata", last_rdata, 32'h0);
        lit("lw_0x41_err", 32'(last_err), 32'd1);
`else
        lit("lw_0x41_rdata", last_rdata, 32'hCAFEF00D);
        lit("lw_0x41_err", 32'(last_err), 32'd0);
`endif

        do_req(1'b0, 3'd3, 32'h10, 32'h0, 0);
        lit("f3_3_err", 32'(last_err), 32'd1);
        lit("f3_3_rdata", last_rdata, 32'h0);

        do_req(1'b1, 3'd2, 32'h50, 32'h0, 0);
        do_req(1'b1, 3'd1, 32'h52, 32'h00001234, 1);
        idle(1);
        do_req(1'b0, 3'd2, 32'h50, 32'h0, 0);
        lit("sh_abort_lw_0x50", last_rdata, 32'h00340000);

        do_req(1'b1, 3'd2, 32'h00004010, 32'h01234567, 0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
        lit("wrap_lw_0x10", last_rdata, 32'h01234567);

        repeat (500) begin
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a |= $urandom & 32'hFFFFC000;
            do_req(1'($urandom), 3'($urandom), a, $urandom, 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
